// File: rtl/char_box_reader.sv
// char_box_reader: walks the row/column projection border tables once per
// projection-done event and streams per-character bounding boxes row-major
// over a valid/ready interface.
module char_box_reader #(
    parameter int NUM_ROW = 1,
    parameter int NUM_COL = 4,
    parameter int DEPBIT  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              project_done_flag,
    input  logic [3:0]        num_col,
    input  logic [3:0]        num_row,
    output logic [DEPBIT-1:0] col_border_addr_rd,
    input  logic [DEPBIT-1:0] col_border_data_rd,
    output logic [DEPBIT-1:0] row_border_addr_rd,
    input  logic [DEPBIT-1:0] row_border_data_rd,
    output logic              box_valid,
    input  logic              box_ready,
    output logic [DEPBIT-1:0] box_top,
    output logic [DEPBIT-1:0] box_bottom,
    output logic [DEPBIT-1:0] box_left,
    output logic [DEPBIT-1:0] box_right,
    output logic [3:0]        box_row_idx,
    output logic [3:0]        box_col_idx,
    output logic              box_last,
    output logic              box_bad,
    output logic              busy,
    output logic              clamp_err
);

    localparam logic [3:0] MAX_ROW = 4'(NUM_ROW);
    localparam logic [3:0] MAX_COL = 4'(NUM_COL);

    // Each table read takes an address phase (_A) and a data-capture phase (_D).
    typedef enum logic [3:0] {
        S_IDLE, S_ROW_T_A, S_ROW_T_D, S_ROW_B_A, S_ROW_B_D,
        S_COL_L_A, S_COL_L_D, S_COL_R_A, S_COL_R_D, S_OUT
    } state_t;

    state_t     state;
    logic       flag_q;
    logic [3:0] nr;
    logic [3:0] nc;
    logic [3:0] r;
    logic [3:0] c;

    // Entry idx lives at 2*idx+1 (first border) and 2*idx+2 (second border).
    function automatic logic [DEPBIT-1:0] entry_addr(input logic [3:0] idx, input logic second);
        return DEPBIT'({idx, 1'b0}) + (second ? DEPBIT'(2) : DEPBIT'(1));
    endfunction

    // Inverted borders are flagged but still emitted so downstream can decide.
    function automatic logic is_bad(input logic [DEPBIT-1:0] t, input logic [DEPBIT-1:0] b,
                                    input logic [DEPBIT-1:0] l, input logic [DEPBIT-1:0] rr);
        return (t > b) || (l > rr);
    endfunction

    logic       start_edge;
    logic       row_clamp;
    logic       col_clamp;
    logic [3:0] nr_eff;
    logic [3:0] nc_eff;

    assign start_edge  = project_done_flag && !flag_q;
    assign row_clamp   = num_row > MAX_ROW;
    assign col_clamp   = num_col > MAX_COL;
    assign nr_eff      = row_clamp ? MAX_ROW : num_row;
    assign nc_eff      = col_clamp ? MAX_COL : num_col;
    assign box_row_idx = r;
    assign box_col_idx = c;

    // Walk FSM: table reads, box assembly and output handshake, all registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= S_IDLE;
            // A level that is already high across reset is not a fresh edge.
            flag_q             <= 1'b1;
            nr                 <= '0;
            nc                 <= '0;
            r                  <= '0;
            c                  <= '0;
            col_border_addr_rd <= '0;
            row_border_addr_rd <= '0;
            box_valid          <= 1'b0;
            box_top            <= '0;
            box_bottom         <= '0;
            box_left           <= '0;
            box_right          <= '0;
            box_last           <= 1'b0;
            box_bad            <= 1'b0;
            busy               <= 1'b0;
            clamp_err          <= 1'b0;
        end else begin
            flag_q <= project_done_flag;
            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        nr        <= nr_eff;
                        nc        <= nc_eff;
                        r         <= '0;
                        c         <= '0;
                        clamp_err <= clamp_err | row_clamp | col_clamp;
                        if (nr_eff != 4'd0 && nc_eff != 4'd0) begin
                            row_border_addr_rd <= entry_addr(4'd0, 1'b0);
                            busy               <= 1'b1;
                            state              <= S_ROW_T_A;
                        end
                    end
                end
                S_ROW_T_A: state <= S_ROW_T_D;
                S_ROW_T_D: begin
                    box_top            <= row_border_data_rd;
                    row_border_addr_rd <= entry_addr(r, 1'b1);
                    state              <= S_ROW_B_A;
                end
                S_ROW_B_A: state <= S_ROW_B_D;
                S_ROW_B_D: begin
                    box_bottom         <= row_border_data_rd;
                    row_border_addr_rd <= '0;
                    col_border_addr_rd <= entry_addr(c, 1'b0);
                    state              <= S_COL_L_A;
                end
                S_COL_L_A: state <= S_COL_L_D;
                S_COL_L_D: begin
                    box_left           <= col_border_data_rd;
                    col_border_addr_rd <= entry_addr(c, 1'b1);
                    state              <= S_COL_R_A;
                end
                S_COL_R_A: state <= S_COL_R_D;
                S_COL_R_D: begin
                    box_right          <= col_border_data_rd;
                    col_border_addr_rd <= '0;
                    box_bad            <= is_bad(box_top, box_bottom, box_left, col_border_data_rd);
                    box_last           <= (r == nr - 4'd1) && (c == nc - 4'd1);
                    box_valid          <= 1'b1;
                    state              <= S_OUT;
                end
                S_OUT: begin
                    if (box_ready) begin
                        box_valid <= 1'b0;
                        box_last  <= 1'b0;
                        if (c != nc - 4'd1) begin
                            c                  <= c + 4'd1;
                            col_border_addr_rd <= entry_addr(c + 4'd1, 1'b0);
                            state              <= S_COL_L_A;
                        end else if (r != nr - 4'd1) begin
                            r                  <= r + 4'd1;
                            c                  <= '0;
                            row_border_addr_rd <= entry_addr(r + 4'd1, 1'b0);
                            state              <= S_ROW_T_A;
                        end else begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_char_box_reader.sv
// Directed bench for char_box_reader: border RAM models with one-cycle read
// latency, a walk driver with stall/toggle/reset hooks, and hand-computed boxes.
module tb_char_box_reader;
    localparam int DEPBIT = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              project_done_flag = 1'b0;
    logic [3:0]        num_col = 4'd0;
    logic [3:0]        num_row = 4'd0;
    logic [DEPBIT-1:0] col_addr, row_addr;
    logic [DEPBIT-1:0] col_data = '0;
    logic [DEPBIT-1:0] row_data = '0;
    logic              box_valid, box_ready = 1'b0;
    logic [DEPBIT-1:0] box_top, box_bottom, box_left, box_right;
    logic [3:0]        box_row_idx, box_col_idx;
    logic              box_last, box_bad, busy, clamp_err;

    char_box_reader #(.NUM_ROW(1), .NUM_COL(4), .DEPBIT(DEPBIT)) dut (
        .clk(clk), .rst(rst), .project_done_flag(project_done_flag),
        .num_col(num_col), .num_row(num_row),
        .col_border_addr_rd(col_addr), .col_border_data_rd(col_data),
        .row_border_addr_rd(row_addr), .row_border_data_rd(row_data),
        .box_valid(box_valid), .box_ready(box_ready),
        .box_top(box_top), .box_bottom(box_bottom), .box_left(box_left), .box_right(box_right),
        .box_row_idx(box_row_idx), .box_col_idx(box_col_idx),
        .box_last(box_last), .box_bad(box_bad), .busy(busy), .clamp_err(clamp_err)
    );

    always #5 clk = ~clk;

    logic [DEPBIT-1:0] col_mem [0:(1<<DEPBIT)-1];
    logic [DEPBIT-1:0] row_mem [0:(1<<DEPBIT)-1];

    // Synchronous-read border RAMs
    always @(posedge clk) begin
        col_data <= col_mem[col_addr];
        row_data <= row_mem[row_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Captured walk results
    int got_n, first_vcyc, busy_cyc, valid_seen;
    logic [DEPBIT-1:0] g_t[8], g_b[8], g_l[8], g_r[8];
    logic [3:0] g_ri[8], g_ci[8];
    logic g_last[8], g_bad[8];
    int g_vc[8];
    // Hooks: stall_box/stall_len hold ready low, toggle_at re-toggles the flag, rst_box resets in OUT
    int stall_box = -1, stall_len = 0, toggle_at = -1, rst_box = -1;
    // Expected column pairs for the current frame
    int e_l[4], e_r[4], e_bad[4];

    task automatic run_walk(input string tag, input int max_cyc, input bit expect_done);
        int stalled, cur_vc;
        bit done, prev_valid;
        logic [DEPBIT-1:0] s_l, s_r, s_t;
        logic [3:0] s_ci;
        got_n = 0; first_vcyc = -1; busy_cyc = 0; valid_seen = 0;
        stalled = 0; cur_vc = 0; done = 0; prev_valid = 0;
        s_l = '0; s_r = '0; s_t = '0; s_ci = '0;
        @(negedge clk); project_done_flag = 1'b0; box_ready = 1'b0;
        @(negedge clk); project_done_flag = 1'b1;
        for (int k = 1; k <= max_cyc && !done; k++) begin
            @(negedge clk);
            if (toggle_at == k) project_done_flag = 1'b0;
            if (toggle_at >= 0 && toggle_at + 2 == k) project_done_flag = 1'b1;
            if (busy) busy_cyc++;
            if (box_valid) begin
                valid_seen++;
                if (!prev_valid) cur_vc = k;
                if (first_vcyc < 0) first_vcyc = k;
                if (rst_box == got_n) begin
                    rst = 1'b1; box_ready = 1'b0; done = 1;
                end else begin
                    if (stall_box == got_n) begin
                        if (stalled == 0) begin
                            s_l = box_left; s_r = box_right; s_t = box_top; s_ci = box_col_idx;
                        end else begin
                            check({tag, "_stall_left"}, 32'(box_left), 32'(s_l));
                            check({tag, "_stall_right"}, 32'(box_right), 32'(s_r));
                            check({tag, "_stall_top"}, 32'(box_top), 32'(s_t));
                            check({tag, "_stall_cidx"}, 32'(box_col_idx), 32'(s_ci));
                        end
                        box_ready = (stalled >= stall_len);
                        stalled++;
                    end else begin
                        box_ready = 1'b1;
                    end
                    if (box_ready && got_n < 8) begin
                        g_t[got_n] = box_top; g_b[got_n] = box_bottom;
                        g_l[got_n] = box_left; g_r[got_n] = box_right;
                        g_ri[got_n] = box_row_idx; g_ci[got_n] = box_col_idx;
                        g_last[got_n] = box_last; g_bad[got_n] = box_bad;
                        g_vc[got_n] = cur_vc;
                        got_n++;
                        if (box_last) done = 1;
                    end
                end
            end else begin
                box_ready = 1'b0;
            end
            prev_valid = box_valid;
        end
        if (expect_done && !done) check({tag, "_timeout"}, 32'd1, 32'd0);
        if (!rst) begin
            @(negedge clk); box_ready = 1'b0;
        end
    endtask

    task automatic verify_frame(input string tag, input int exp_n);
        check({tag, "_count"}, 32'(got_n), 32'(exp_n));
        for (int i = 0; i < exp_n && i < got_n; i++) begin
            check($sformatf("%s_b%0d_top", tag, i), 32'(g_t[i]), 32'd20);
            check($sformatf("%s_b%0d_bottom", tag, i), 32'(g_b[i]), 32'd60);
            check($sformatf("%s_b%0d_left", tag, i), 32'(g_l[i]), 32'(e_l[i]));
            check($sformatf("%s_b%0d_right", tag, i), 32'(g_r[i]), 32'(e_r[i]));
            check($sformatf("%s_b%0d_ridx", tag, i), 32'(g_ri[i]), 32'd0);
            check($sformatf("%s_b%0d_cidx", tag, i), 32'(g_ci[i]), 32'(i));
            check($sformatf("%s_b%0d_last", tag, i), 32'(g_last[i]), 32'(i == exp_n - 1));
            check($sformatf("%s_b%0d_bad", tag, i), 32'(g_bad[i]), 32'(e_bad[i]));
        end
    endtask

    task automatic load_tables();
        int cols[8] = '{10, 30, 40, 70, 80, 110, 120, 150};
        row_mem[1] = 10'd20;
        row_mem[2] = 10'd60;
        for (int i = 0; i < 8; i++) col_mem[i + 1] = 10'(cols[i]);
        for (int i = 0; i < 4; i++) begin
            e_l[i] = cols[2 * i]; e_r[i] = cols[2 * i + 1]; e_bad[i] = 0;
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << DEPBIT); i++) begin
            col_mem[i] = 10'h3FF; row_mem[i] = 10'h3FF;
        end
        load_tables();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(box_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_col_addr", 32'(col_addr), 32'd0);
        check("rst_row_addr", 32'(row_addr), 32'd0);
        check("rst_clamp", 32'(clamp_err), 32'd0);
        check("rst_last", 32'(box_last), 32'd0);
        rst = 1'b0;
        num_row = 4'd1; num_col = 4'd4;

        // 1: basic frame, ready always high
        run_walk("t1", 200, 1);
        verify_frame("t1", 4);
        check("t1_first_valid", 32'(first_vcyc), 32'd9);
        check("t1_box1_valid", 32'(g_vc[1]), 32'd14);
        check("t1_box3_valid", 32'(g_vc[3]), 32'd24);
        check("t1_busy_cycles", 32'(busy_cyc), 32'd24);
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_idle_valid", 32'(box_valid), 32'd0);
        check("t1_idle_col_addr", 32'(col_addr), 32'd0);
        check("t1_idle_row_addr", 32'(row_addr), 32'd0);
        check("t1_clamp", 32'(clamp_err), 32'd0);

        // 2: ready held low for 7 cycles on box 2
        stall_box = 1; stall_len = 7;
        run_walk("t2", 200, 1);
        stall_box = -1; stall_len = 0;
        verify_frame("t2", 4);
        check("t2_box2_valid", 32'(g_vc[2]), 32'd26);
        check("t2_busy_cycles", 32'(busy_cyc), 32'd31);

        // 3: column count clamped, then a zero-row frame
        num_col = 4'd6;
        run_walk("t3a", 200, 1);
        verify_frame("t3a", 4);
        check("t3a_clamp", 32'(clamp_err), 32'd1);
        num_col = 4'd4; num_row = 4'd0;
        run_walk("t3b", 20, 0);
        check("t3b_valid_cycles", 32'(valid_seen), 32'd0);
        check("t3b_busy_le1", 32'(busy_cyc <= 1), 32'd1);
        check("t3b_clamp_sticky", 32'(clamp_err), 32'd1);
        num_row = 4'd1;

        // 4: flag re-toggled mid-walk, then a fresh edge restarts from index 0
        toggle_at = 3;
        run_walk("t4a", 200, 1);
        toggle_at = -1;
        verify_frame("t4a", 4);
        repeat (15) begin
            @(negedge clk);
            if (box_valid) valid_seen++;
        end
        check("t4a_no_extra", 32'(valid_seen), 32'd4);
        run_walk("t4b", 200, 1);
        verify_frame("t4b", 4);
        check("t4b_first_valid", 32'(first_vcyc), 32'd9);

        // 5: reset while box 3 is presented
        num_col = 4'd6;
        rst_box = 2;
        run_walk("t5", 200, 1);
        rst_box = -1;
        check("t5_boxes_before", 32'(got_n), 32'd2);
        @(negedge clk);
        check("t5_valid", 32'(box_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_col_addr", 32'(col_addr), 32'd0);
        check("t5_row_addr", 32'(row_addr), 32'd0);
        check("t5_clamp_clr", 32'(clamp_err), 32'd0);
        rst = 1'b0;
        valid_seen = 0;
        busy_cyc = 0;
        repeat (20) begin
            @(negedge clk);
            if (box_valid) valid_seen++;
            if (busy) busy_cyc++;
        end
        check("t5_no_more_boxes", 32'(valid_seen), 32'd0);
        check("t5_stays_idle", 32'(busy_cyc), 32'd0);
        num_col = 4'd4;

        // 6: inverted column entry is flagged but passed through
        col_mem[3] = 10'd200; col_mem[4] = 10'd5;
        e_l[1] = 200; e_r[1] = 5; e_bad[1] = 1;
        run_walk("t6", 200, 1);
        verify_frame("t6", 4);
        check("t6_clamp", 32'(clamp_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
